// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit after ptr, wrapping modulo NREQ.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    int j;
    j      = 0;
    any    = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && mask[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among NREQ writers, with bounded tenure.
//
// state    | meaning
// ST_IDLE  | no grant; waiting for any request
// ST_GRANT | owner holds grant and writes q while it keeps requesting
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       wdata,
  output logic [NREQ-1:0]          grant,
  output logic [clog2(NREQ)-1:0]   owner,
  output logic                     busy,
  output logic [DW-1:0]            q,
  output logic                     q_valid
);

  localparam int IW = clog2(NREQ);
  localparam int HW = clog2(MAX_HOLD + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   q_q, q_d;
  logic            q_valid_q, q_valid_d;

  logic [NREQ-1:0] others;
  logic            own_req;
  logic            hold_ok;
  logic [NREQ-1:0] pick_mask;
  logic [IW-1:0]   pick_ptr;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  assign others  = req & ~(NREQ'(1) << owner_q);
  assign own_req = req[owner_q];
  assign hold_ok = (hold_q < HW'(MAX_HOLD)) || (others == '0);

  // In GRANT the search starts after the owner, which becomes the new pointer on release.
  assign pick_ptr  = (state_q == ST_GRANT) ? owner_q : ptr_q;
  assign pick_mask = (state_q == ST_GRANT && own_req) ? others : req;

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          grant_d = pick_oh;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (own_req && hold_ok) begin
          q_d       = wdata[int'(owner_q)*DW +: DW];
          q_valid_d = 1'b1;
          if (hold_q < HW'(MAX_HOLD)) hold_d = hold_q + HW'(1);
        end else begin
          ptr_d = owner_q;
          if (pick_any) begin
            grant_d = pick_oh;
            owner_d = pick_idx;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (grant_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= IW'(NREQ - 1);
      hold_q    <= '0;
      busy_q    <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed and random stimulus for shared_reg_arbiter, checked against a rule-level model.
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      grant;
  logic [1:0]           owner;
  logic                 busy;
  logic [DW-1:0]        q;
  logic                 q_valid;

  shared_reg_arbiter #(
    .NREQ     (NREQ),
    .DW       (DW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .q       (q),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_q;
  bit m_qv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int rr_winner(input int mask, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_ptr   = NREQ - 1;
    m_hold  = 0;
    m_q     = 0;
    m_qv    = 0;
  endtask

  task automatic model_edge();
    int r, o, others, cand, w;
    r = int'(req);
    if (!m_busy) begin
      m_qv = 0;
      if (r != 0) begin
        m_busy  = 1;
        m_owner = rr_winner(r, m_ptr);
        m_hold  = 0;
      end
    end else begin
      o      = m_owner;
      others = r & ~(1 << o);
      if (r[o] && (m_hold < MAX_HOLD || others == 0)) begin
        m_q    = int'(wdata[o*DW +: DW]);
        m_qv   = 1;
        m_hold = (m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1;
      end else begin
        m_ptr = o;
        m_qv  = 0;
        cand  = r[o] ? others : r;
        if (cand != 0) begin
          w       = rr_winner(cand, o);
          m_owner = w;
          m_hold  = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
    check_eq("owner", 32'(owner), 32'(m_owner));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("q", 32'(q), 32'(m_q));
    check_eq("q_valid", 32'(q_valid), 32'(m_qv));
  endtask

  // Advance one clock edge, then check 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  // Assert reset between edges; outputs must clear without any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  task automatic set_wd(input int i, input logic [DW-1:0] v);
    wdata[i*DW +: DW] = v;
  endtask

  initial begin
    rst   = 1'b1;
    req   = NREQ'($urandom);
    wdata = {$urandom, $urandom};
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    req = '0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // single requester
    req = 4'b0010;
    set_wd(1, 8'hA5);
    step();
    check_eq("single_grant", 32'(grant), 32'b0010);
    step();
    check_eq("single_q", 32'(q), 32'hA5);
    check_eq("single_qv", 32'(q_valid), 32'd1);
    req = '0;
    step();
    check_eq("single_drop", 32'(grant), 32'd0);

    // lone hold with incrementing data
    req = 4'b0001;
    step();
    for (int i = 0; i < 10; i++) begin
      set_wd(0, DW'(8'h10 + i));
      step();
      check_eq("lone_q", 32'(q), 32'(8'h10 + i));
    end
    req = '0;
    step();

    // full contention from reset
    async_reset();
    req = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      wdata = {$urandom, $urandom};
      step();
    end

    // early release of owner 2 while 0 and 3 wait
    async_reset();
    req = 4'b0100;
    step();
    step();
    req = 4'b1001;
    step();
    check_eq("early_grant", 32'(grant), 32'b1000);
    for (int i = 0; i < 5; i++) step();
    check_eq("early_next", 32'(grant), 32'b0001);

    // reset mid-tenure
    req = 4'b1111;
    step();
    step();
    async_reset();
    step();
    check_eq("post_reset_grant", 32'(grant), 32'b0001);

    // random traffic with occasional async resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
      wdata = {$urandom, $urandom};
      if ($urandom_range(0, 79) == 0) async_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
